// File: rtl/writeback_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | writeback_stage : final pipeline stage, commits one instruction per cycle  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module writeback_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         ir_i,
    input  logic [XLEN-1:0]     pc_i,
    input  logic [XLEN-1:0]     alu_i,
    input  logic                br_taken_i,
    input  logic                mem_valid_i,
    input  logic [31:0]         mem_rdata_i,
    output logic                rf_we_o,
    output logic [4:0]          rf_waddr_o,
    output logic [XLEN-1:0]     rf_wdata_o,
    output logic                pc_valid_o,
    output logic [XLEN-1:0]     pc_o,
    output logic                illegal_o,
    output logic [RETIRE_W-1:0] retire_cnt_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_COMMIT   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           ir_q, ir_d;
    logic [XLEN-1:0]       ipc_q, ipc_d;
    logic [XLEN-1:0]       alu_q, alu_d;
    logic                  br_q, br_d;
    logic                  rf_we_q, rf_we_d;
    logic [4:0]            rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
    logic                  pc_valid_q, pc_valid_d;
    logic [XLEN-1:0]       npc_q, npc_d;
    logic                  illegal_q, illegal_d;
    logic [RETIRE_W-1:0]   retire_q, retire_d;

    logic [31:0]     src_ir;
    logic [XLEN-1:0] src_pc, src_alu;
    logic            src_br;
    logic [XLEN-1:0] seq_pc, u_imm, j_imm, ld_data, wr_data, next_pc;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic            wr_en, illegal, commit;

    // A load commits from the latched copy; everything else commits straight off the input.
    always_comb begin
        src_ir  = (state_q == ST_WAIT_MEM) ? ir_q  : ir_i;
        src_pc  = (state_q == ST_WAIT_MEM) ? ipc_q : pc_i;
        src_alu = (state_q == ST_WAIT_MEM) ? alu_q : alu_i;
        src_br  = (state_q == ST_WAIT_MEM) ? br_q  : br_taken_i;

        seq_pc  = src_pc + XLEN'(4);
        u_imm   = XLEN'($signed({src_ir[31:12], 12'b0}));
        j_imm   = XLEN'($signed({src_ir[31], src_ir[19:12], src_ir[20], src_ir[30:21], 1'b0}));
        ld_byte = mem_rdata_i[{src_alu[1:0], 3'b000} +: 8];
        ld_half = src_alu[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

        case (src_ir[14:12])
            3'b000:  ld_data = XLEN'($signed(ld_byte));
            3'b001:  ld_data = XLEN'($signed(ld_half));
            3'b100:  ld_data = XLEN'(ld_byte);
            3'b101:  ld_data = XLEN'(ld_half);
            default: ld_data = XLEN'($signed(mem_rdata_i));
        endcase

        wr_en   = 1'b0;
        wr_data = src_alu;
        next_pc = seq_pc;
        illegal = 1'b0;
        case (src_ir[6:0])
            OP_REG, OP_IMM: wr_en = 1'b1;
            OP_LUI: begin
                wr_en   = 1'b1;
                wr_data = u_imm;
            end
            OP_AUIPC: begin
                wr_en   = 1'b1;
                wr_data = src_pc + u_imm;
            end
            OP_JAL: begin
                wr_en   = 1'b1;
                wr_data = seq_pc;
                next_pc = src_pc + j_imm;
            end
            OP_JALR: begin
                wr_en   = 1'b1;
                wr_data = seq_pc;
                next_pc = {src_alu[XLEN-1:1], 1'b0};
            end
            OP_BRANCH: next_pc = src_br ? src_alu : seq_pc;
            OP_LOAD: begin
                wr_en   = 1'b1;
                wr_data = ld_data;
            end
            OP_STORE: wr_en = 1'b0;
            default:  illegal = 1'b1;
        endcase
        if (src_ir[11:7] == 5'd0) begin
            wr_en = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ipc_d   = ipc_q;
        alu_d   = alu_q;
        br_d    = br_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE, ST_COMMIT: begin
                state_d = ST_IDLE;
                if (in_valid_i) begin
                    ir_d  = ir_i;
                    ipc_d = pc_i;
                    alu_d = alu_i;
                    br_d  = br_taken_i;
                    if (ir_i[6:0] == OP_LOAD) begin
                        state_d = ST_WAIT_MEM;
                    end else begin
                        state_d = ST_COMMIT;
                        commit  = 1'b1;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (mem_valid_i) begin
                    state_d = ST_COMMIT;
                    commit  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rf_we_d    = commit & wr_en;
        rf_waddr_d = (commit & wr_en) ? src_ir[11:7] : rf_waddr_q;
        rf_wdata_d = (commit & wr_en) ? wr_data : rf_wdata_q;
        pc_valid_d = commit;
        npc_d      = commit ? next_pc : npc_q;
        illegal_d  = commit & illegal;
        retire_d   = commit ? retire_q + RETIRE_W'(1) : retire_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            ipc_q      <= '0;
            alu_q      <= '0;
            br_q       <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pc_valid_q <= 1'b0;
            npc_q      <= RESET_PC;
            illegal_q  <= 1'b0;
            retire_q   <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ipc_q      <= ipc_d;
            alu_q      <= alu_d;
            br_q       <= br_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pc_valid_q <= pc_valid_d;
            npc_q      <= npc_d;
            illegal_q  <= illegal_d;
            retire_q   <= retire_d;
        end
    end

    assign in_ready_o   = (state_q != ST_WAIT_MEM);
    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign rf_wdata_o   = rf_wdata_q;
    assign pc_valid_o   = pc_valid_q;
    assign pc_o         = npc_q;
    assign illegal_o    = illegal_q;
    assign retire_cnt_o = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_writeback_stage : randomized bench with behavioural commit model        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_writeback_stage;

    localparam int          XLEN = 32;
    localparam int          RW   = 4;
    localparam logic [31:0] RPC  = 32'h100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [31:0]   ir_i = '0;
    logic [31:0]   pc_i = '0;
    logic [31:0]   alu_i = '0;
    logic          br_taken_i = 1'b0;
    logic          mem_valid_i = 1'b0;
    logic [31:0]   mem_rdata_i = '0;
    logic          rf_we_o;
    logic [4:0]    rf_waddr_o;
    logic [31:0]   rf_wdata_o;
    logic          pc_valid_o;
    logic [31:0]   pc_o;
    logic          illegal_o;
    logic [RW-1:0] retire_cnt_o;

    writeback_stage #(.XLEN(XLEN), .RESET_PC(RPC), .RETIRE_W(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .ir_i(ir_i), .pc_i(pc_i), .alu_i(alu_i), .br_taken_i(br_taken_i),
        .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .pc_valid_o(pc_valid_o), .pc_o(pc_o), .illegal_o(illegal_o),
        .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural view expected by the model
    logic [RW-1:0] m_cnt = '0;
    logic [31:0]   m_pc  = RPC;
    logic          e_we;
    logic [38:0]   e_core;
    logic [36:0]   e_wr;

    wire [38:0] obs_core = {rf_we_o, pc_valid_o, pc_o, illegal_o, retire_cnt_o};
    wire [36:0] obs_wr   = {rf_waddr_o, rf_wdata_o};

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        logic signed [31:0] t;
        t = $signed(v << (32 - bits));
        return 32'(t >>> (32 - bits));
    endfunction

    task automatic model_commit(input logic [31:0] ir, input logic [31:0] pc,
                                input logic [31:0] alu, input logic br,
                                input logic [31:0] rdata);
        logic        wr, ill;
        logic [31:0] wd, npc, word, half;
        wr   = 1'b0;
        ill  = 1'b0;
        wd   = '0;
        npc  = pc + 32'd4;
        word = rdata >> (8 * alu[1:0]);
        half = rdata >> (16 * alu[1]);
        case (ir[6:0])
            7'h13, 7'h33: begin wr = 1'b1; wd = alu; end
            7'h37: begin wr = 1'b1; wd = ir & 32'hFFFF_F000; end
            7'h17: begin wr = 1'b1; wd = pc + (ir & 32'hFFFF_F000); end
            7'h6F: begin
                wr  = 1'b1;
                wd  = pc + 32'd4;
                npc = pc + sx({11'b0, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}, 21);
            end
            7'h67: begin wr = 1'b1; wd = pc + 32'd4; npc = alu & 32'hFFFF_FFFE; end
            7'h63: npc = br ? alu : pc + 32'd4;
            7'h23: wr = 1'b0;
            7'h03: begin
                wr = 1'b1;
                case (ir[14:12])
                    3'd0:    wd = sx(word, 8);
                    3'd1:    wd = sx(half, 16);
                    3'd4:    wd = word & 32'hFF;
                    3'd5:    wd = half & 32'hFFFF;
                    default: wd = rdata;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ir[11:7] == 5'd0) wr = 1'b0;
        m_cnt  = m_cnt + 1'b1;
        m_pc   = npc;
        e_we   = wr;
        e_core = {wr, 1'b1, npc, ill, m_cnt};
        e_wr   = {ir[11:7], wd};
    endtask

    // Presents one instruction from a negedge and returns at the negedge of its commit cycle.
    task automatic drive(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] alu,
                         input logic br, input logic [31:0] rdata, input int dly,
                         output bit ok);
        ok          = (in_ready_o === 1'b1);
        in_valid_i  = 1'b1;
        ir_i        = ir;
        pc_i        = pc;
        alu_i       = alu;
        br_taken_i  = br;
        mem_valid_i = 1'($urandom);
        mem_rdata_i = (ir[6:0] == 7'h03) ? $urandom : rdata;
        @(posedge clk);
        #1;
        in_valid_i  = 1'b0;
        mem_valid_i = 1'b0;
        ir_i        = $urandom;
        pc_i        = $urandom;
        alu_i       = $urandom;
        br_taken_i  = 1'($urandom);
        if (ir[6:0] == 7'h03) begin
            for (int k = 0; k < dly; k++) begin
                @(negedge clk);
                if (in_ready_o !== 1'b0 || pc_valid_o !== 1'b0) ok = 0;
                in_valid_i  = 1'b1;
                mem_rdata_i = $urandom;
            end
            @(negedge clk);
            if (in_ready_o !== 1'b0) ok = 0;
            in_valid_i  = 1'b0;
            mem_rdata_i = rdata;
            mem_valid_i = 1'b1;
            @(posedge clk);
            #1;
            mem_valid_i = 1'b0;
            mem_rdata_i = $urandom;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs_core !== {2'b00, RPC, 1'b0, 4'd0} || obs_wr !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got core=%h wr=%h, expected core=%h wr=0",
                     obs_core, obs_wr, {2'b00, RPC, 1'b0, 4'd0});
        end
        n_checks++;
        if (in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, expected 1", in_ready_o);
        end
        rst_n = 1'b1;
        m_cnt = '0;
        m_pc  = RPC;
        @(negedge clk);
        n_checks++;
        if (pc_o !== RPC || pc_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got pc=%h pcv=%b, expected pc=%h pcv=0", pc_o, pc_valid_o, RPC);
        end
    endtask

    task automatic test_addi();
        bit ok;
        drive(32'h00A0_0293, 32'h100, 32'd10, 1'b0, 32'h0, 0, ok);
        model_commit(32'h00A0_0293, 32'h100, 32'd10, 1'b0, 32'h0);
        n_checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'd10 ||
            pc_o !== 32'h104 || retire_cnt_o !== 4'd1 || pc_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL addi: got we=%b wa=%0d wd=%h pc=%h cnt=%0d pcv=%b, expected 1 5 0000000a 00000104 1 1",
                     rf_we_o, rf_waddr_o, rf_wdata_o, pc_o, retire_cnt_o, pc_valid_o);
        end
        mem_valid_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (obs_core !== {2'b00, m_pc, 1'b0, m_cnt}) begin
                n_fail++;
                $display("FAIL idle_hold: got %h, expected %h", obs_core, {2'b00, m_pc, 1'b0, m_cnt});
            end
        end
        mem_valid_i = 1'b0;
    endtask

    task automatic test_loads();
        bit            ok;
        logic [31:0]   irs [3] = '{32'h0000_0303, 32'h0000_4303, 32'h0000_1303};
        logic [31:0]   als [3] = '{32'h1003, 32'h1003, 32'h1002};
        logic [31:0]   wds [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};
        logic [31:0]   ir, al, rd;
        for (int i = 0; i < 3; i++) begin
            drive(irs[i], 32'h300, als[i], 1'b0, 32'h80FF_1234, 3, ok);
            model_commit(irs[i], 32'h300, als[i], 1'b0, 32'h80FF_1234);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL load_wait_%0d: in_ready or pc_valid wrong while waiting, expected ready=0 pcv=0", i);
            end
            n_checks++;
            if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd6 || rf_wdata_o !== wds[i] || pc_o !== 32'h304) begin
                n_fail++;
                $display("FAIL load_dir_%0d: got we=%b wa=%0d wd=%h pc=%h, expected 1 6 %h 00000304",
                         i, rf_we_o, rf_waddr_o, rf_wdata_o, pc_o, wds[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            ir = $urandom;
            ir = {ir[31:15], 3'(i), ir[11:7], 7'h03};
            al = $urandom;
            rd = $urandom;
            drive(ir, 32'h400 + 32'(4 * i), al, 1'b0, rd, i % 4, ok);
            model_commit(ir, 32'h400 + 32'(4 * i), al, 1'b0, rd);
            n_checks++;
            if (!ok || obs_core !== e_core || (e_we && obs_wr !== e_wr)) begin
                n_fail++;
                $display("FAIL load_rand_%0d: got core=%h wr=%h ok=%b, expected core=%h wr=%h",
                         i, obs_core, obs_wr, ok, e_core, e_wr);
            end
        end
    endtask

    task automatic test_jumps();
        bit ok;
        drive(32'hFF9F_F0EF, 32'h200, 32'h0, 1'b0, 32'h0, 0, ok);
        model_commit(32'hFF9F_F0EF, 32'h200, 32'h0, 1'b0, 32'h0);
        n_checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd1 || rf_wdata_o !== 32'h204 || pc_o !== 32'h1F8) begin
            n_fail++;
            $display("FAIL jal: got we=%b wa=%0d wd=%h pc=%h, expected 1 1 00000204 000001f8",
                     rf_we_o, rf_waddr_o, rf_wdata_o, pc_o);
        end
        drive(32'h0001_00E7, 32'h500, 32'h301, 1'b0, 32'h0, 0, ok);
        model_commit(32'h0001_00E7, 32'h500, 32'h301, 1'b0, 32'h0);
        n_checks++;
        if (rf_we_o !== 1'b1 || rf_wdata_o !== 32'h504 || pc_o !== 32'h300) begin
            n_fail++;
            $display("FAIL jalr: got we=%b wd=%h pc=%h, expected 1 00000504 00000300", rf_we_o, rf_wdata_o, pc_o);
        end
    endtask

    task automatic test_branch();
        bit          ok;
        logic [31:0] exp_pc;
        for (int t = 0; t < 2; t++) begin
            exp_pc = (t == 0) ? 32'h80 : 32'h44;
            drive(32'h0400_0463, 32'h40, 32'h80, (t == 0), 32'h0, 0, ok);
            model_commit(32'h0400_0463, 32'h40, 32'h80, (t == 0), 32'h0);
            n_checks++;
            if (pc_o !== exp_pc || rf_we_o !== 1'b0 || pc_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL branch_%0d: got pc=%h we=%b pcv=%b, expected %h 0 1",
                         t, pc_o, rf_we_o, pc_valid_o, exp_pc);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen = 0;
        in_valid_i  = 1'b1;
        ir_i        = 32'h0000_2383;
        pc_i        = 32'h600;
        alu_i       = 32'h2000;
        mem_valid_i = 1'b0;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_core !== {2'b00, RPC, 1'b0, 4'd0} || in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: got core=%h ready=%b, expected core=%h ready=1",
                     obs_core, in_ready_o, {2'b00, RPC, 1'b0, 4'd0});
        end
        @(negedge clk);
        rst_n       = 1'b1;
        m_cnt       = '0;
        m_pc        = RPC;
        mem_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (pc_valid_o !== 1'b0 || retire_cnt_o !== 4'd0) seen = 1;
        end
        mem_valid_i = 1'b0;
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL dropped_load: got a commit after reset, expected none (pcv=%b cnt=%0d)",
                     pc_valid_o, retire_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        bit          ok;
        logic [31:0] ir, al;
        for (int i = 0; i < 4; i++) begin
            ir          = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
            al          = $urandom;
            in_valid_i  = 1'b1;
            ir_i        = ir;
            pc_i        = 32'h1000 + 32'(4 * i);
            alu_i       = al;
            @(posedge clk);
            #1;
            @(negedge clk);
            model_commit(ir, 32'h1000 + 32'(4 * i), al, 1'b0, 32'h0);
            n_checks++;
            if (obs_core !== e_core || obs_wr !== e_wr) begin
                n_fail++;
                $display("FAIL b2b_%0d: got core=%h wr=%h, expected core=%h wr=%h",
                         i, obs_core, obs_wr, e_core, e_wr);
            end
        end
        in_valid_i = 1'b0;
        n_checks++;
        if (retire_cnt_o !== 4'd4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d, expected 4", retire_cnt_o);
        end
        drive(32'h0050_0013, 32'h2000, 32'h5, 1'b0, 32'h0, 0, ok);
        model_commit(32'h0050_0013, 32'h2000, 32'h5, 1'b0, 32'h0);
        n_checks++;
        if (rf_we_o !== 1'b0 || pc_valid_o !== 1'b1 || retire_cnt_o !== 4'd5) begin
            n_fail++;
            $display("FAIL rd_x0: got we=%b pcv=%b cnt=%0d, expected 0 1 5", rf_we_o, pc_valid_o, retire_cnt_o);
        end
    endtask

    task automatic test_illegal();
        bit ok;
        drive(32'h0000_037F, 32'h700, 32'h1234, 1'b1, 32'h0, 0, ok);
        model_commit(32'h0000_037F, 32'h700, 32'h1234, 1'b1, 32'h0);
        n_checks++;
        if (illegal_o !== 1'b1 || rf_we_o !== 1'b0 || pc_o !== 32'h704 || pc_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal: got ill=%b we=%b pc=%h pcv=%b, expected 1 0 00000704 1",
                     illegal_o, rf_we_o, pc_o, pc_valid_o);
        end
        @(negedge clk);
        n_checks++;
        if (illegal_o !== 1'b0 || pc_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_pulse: got ill=%b pcv=%b, expected 0 0", illegal_o, pc_valid_o);
        end
    endtask

    task automatic test_random();
        bit          ok;
        logic [6:0]  ops [10] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h23, 7'h03, 7'h7F};
        logic [6:0]  bad [4]  = '{7'h7F, 7'h0F, 7'h73, 7'h5B};
        logic [6:0]  op;
        logic [31:0] ir, pc, al, rd;
        logic        br;
        int          dly;
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 9)];
            if (op == 7'h7F) op = bad[$urandom_range(0, 3)];
            ir = $urandom;
            ir = {ir[31:7], op};
            if ($urandom_range(0, 7) == 0) ir[11:7] = 5'd0;
            pc  = $urandom & 32'hFFFF_FFFC;
            al  = $urandom;
            rd  = $urandom;
            br  = 1'($urandom);
            dly = $urandom_range(0, 3);
            drive(ir, pc, al, br, rd, dly, ok);
            model_commit(ir, pc, al, br, rd);
            n_checks++;
            if (!ok || obs_core !== e_core || (e_we && obs_wr !== e_wr)) begin
                n_fail++;
                $display("FAIL rand_%0d ir=%h: got core=%h wr=%h ok=%b, expected core=%h wr=%h",
                         i, ir, obs_core, obs_wr, ok, e_core, e_wr);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                n_checks++;
                if (obs_core !== {2'b00, m_pc, 1'b0, m_cnt}) begin
                    n_fail++;
                    $display("FAIL rand_idle_%0d: got %h, expected %h", i, obs_core, {2'b00, m_pc, 1'b0, m_cnt});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_loads();
        test_jumps();
        test_branch();
        test_reset_mid_wait();
        test_back_to_back();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
# writeback_stage

Parametrised final pipeline stage. It accepts one executed instruction per handshake, waits for load data when needed, and commits in a single registered cycle. A commit drives one register-file write port, the next program counter and a retire pulse/counter. It replaces the fixed 32-bit write stage: it adds load byte/halfword extension, JALR, taken/not-taken branches, correctly placed U/J immediates, x0 suppression and a valid/ready handshake toward execute.

## Interface
- XLEN, 32: datapath width, 32 or 64; all PC/data arithmetic is modulo 2^XLEN
- RESET_PC, 0: value of pc_o while reset is asserted and after release
- RETIRE_W, 32: width of retire counter
- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-low reset
- in_valid_i  in  1  execute presents an instruction
- in_ready_o  out  1  stage can accept (handshake = in_valid_i & in_ready_o at posedge)
- ir_i  in  32  instruction word; opcodes from opcode.v
- pc_i  in  XLEN  PC of the instruction
- alu_i  in  XLEN  ALU result: R/I result, load address, JALR target (rs1+imm), branch target
- br_taken_i  in  1  branch condition result (B-type only)
- mem_valid_i  in  1  load data valid (sampled only in WAIT_MEM)
- mem_rdata_i  in  32  aligned 32-bit word containing the load address
- rf_we_o  out  1  register write strobe, one cycle
- rf_waddr_o  out  5  destination ir[11:7]
- rf_wdata_o  out  XLEN  write data
- pc_valid_o  out  1  next-PC strobe, one cycle per retired instruction
- pc_o  out  XLEN  next PC; holds its value between strobes
- illegal_o  out  1  one-cycle pulse when an unrecognised opcode retires
- retire_cnt_o  out  RETIRE_W  count of retired instructions; wraps to 0

## Operation
- FSM states:
  - IDLE: in_ready_o=1.
  - WAIT_MEM: in_ready_o=0.
  - COMMIT: in_ready_o=1.
- Accept in IDLE or COMMIT: latch ir/pc/alu/br_taken. Opcode LOAD goes to WAIT_MEM; all others go to COMMIT.
- COMMIT without a new accept goes to IDLE.
- WAIT_MEM with mem_valid_i=1 latches the extended load data and goes to COMMIT. Otherwise it stays.
- COMMIT cycle asserts pc_valid_o, increments retire_cnt_o, and asserts rf_we_o for R, I, LOAD, LUI, AUIPC, JAL, JALR when ir[11:7]≠0.
- S, B and unknown opcodes never write. rd=x0 never writes.
- Write data:
  - R/I: alu_i.
  - LUI: sext({ir[31:12],12'b0}).
  - AUIPC: pc_i + sext({ir[31:12],12'b0}).
  - JAL/JALR: pc_i + 4.
  - LOAD: depends on funct3=ir[14:12], with byte lane from alu_i[1:0]:
    - 000 LB: sign-extend byte.
    - 001 LH: sign-extend halfword at alu_i[1].
    - 010 LW: sign-extend word to XLEN.
    - 100 LBU: zero-extend byte.
    - 101 LHU: zero-extend halfword.
    - Other funct3: treat as LW.
- Next PC:
  - JAL: pc_i + sext({ir[31],ir[19:12],ir[20],ir[30:21],1'b0}).
  - JALR: alu_i & ~1.
  - B: br_taken_i ? alu_i : pc_i+4.
  - All others, including unknown: pc_i+4.
- Unknown opcode: no register write, next PC = pc_i+4, illegal_o pulses with pc_valid_o.
- Reset asserted, asynchronously: state=IDLE, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, pc_valid_o=0, pc_o=RESET_PC, illegal_o=0, retire_cnt_o=0. An instruction in WAIT_MEM is discarded.

## Timing
- All outputs are registered; no combinational path from inputs to outputs except in_ready_o, which is state-decoded.
- Non-load: accepted at edge N, commit strobes high in cycle N..N+1 and low after edge N+1 unless another commit follows.
- Back-to-back non-loads: one commit per cycle (accept during COMMIT).
- Load: accepted at edge N, mem_valid_i sampled first at edge N+1; if sampled high at edge M, commit occurs in cycle M..M+1. Minimum load latency is 2 cycles from accept.
- mem_valid_i is ignored outside WAIT_MEM. in_valid_i is ignored while in_ready_o=0.
- retire_cnt_o updates on the same edge that raises pc_valid_o. It goes from 2^RETIRE_W−1 to 0 without an error.
- Simultaneous commit and accept: the new instruction's strobes follow in the next cycle with no gap.

## Test plan
- Reset with pc_o held at RESET_PC=0x100, then ADDI x5 (ir=0x00A00293), pc=0x100, alu=10 -> one cycle later rf_we=1, waddr=5, wdata=10, pc_o=0x104, retire_cnt=1.
- LB at alu=0x1003 with mem_rdata=0x80FF_1234 and mem_valid delayed 3 cycles -> in_ready low while waiting; wdata=0xFFFF_FF80. The same test with LBU gives 0x0000_0080; LH at alu=0x1002 gives 0xFFFF_80FF.
- JAL x1 with offset −8 (ir=0xFF9FF0EF), pc=0x200 -> wdata=0x204, pc_o=0x1F8. JALR with alu=0x301 -> pc_o=0x300.
- BEQ at pc=0x40, alu=0x80: taken gives pc_o=0x80; not taken gives 0x44; rf_we=0 in both cases.
- Four back-to-back ADDI with in_valid held high -> four consecutive commit cycles, retire_cnt=4. An ADDI with rd=x0 retires with rf_we=0.
- Reset asserted mid-WAIT_MEM -> outputs clear immediately (asynchronous); after release no commit occurs for the dropped load. An unknown opcode 0x7F retires with illegal_o=1 and pc+4.
